// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle shifter/rotator that moves one bit position per clock.
//
// A start accepted in IDLE or DONE latches the operand, the operation and the count.
// The unit then shifts or rotates result by one position on every edge until the count
// is used up, and pulses done for one cycle. result and c hold their values until the
// next accepted start.
//
// Parameters
//   WIDTH        data/result width in bits
//   CNT_W        shift_count width; 2**CNT_W-1 must be less than WIDTH
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request strobe, ignored while busy
//   shift_count  number of bit positions to move
//   data         operand
//   operation    00 SLL, 01 SRL (SRA when SHIFT_ARITH_EN), 10 ROL, 11 ROR
//   result       registered operand/result
//   c            registered carry: last bit shifted out or wrapped
//   busy         high while an operation is in progress
//   done         one-cycle completion pulse
//
// Build option
//   SHIFT_ARITH_EN  when defined, operation 01 is an arithmetic right shift
//                   (old MSB replicated into the MSB); otherwise it is logical.

module serial_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   step_val;
  logic               step_c;

  // Start is only honoured when no operation is in flight.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // The edge that consumes the final position also completes; a zero count
  // still spends one cycle in BUSY.
  assign last_step = (rem_q == '0) || (rem_q == CNT_W'(1));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      c_q      <= 1'b0;
      op_q     <= 2'b00;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      c_q      <= c_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
    end
  end

  // One-position move of the current result according to the latched operation.
  always_comb begin
    step_val = result_q;
    step_c   = 1'b0;
    unique case (op_q)
      2'b00: begin
        step_val = {result_q[WIDTH-2:0], 1'b0};
        step_c   = result_q[WIDTH-1];
      end
      2'b01: begin
`ifdef SHIFT_ARITH_EN
        step_val = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`else
        step_val = {1'b0, result_q[WIDTH-1:1]};
`endif
        step_c   = result_q[0];
      end
      2'b10: begin
        step_val = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
        step_c   = result_q[WIDTH-1];
      end
      2'b11: begin
        step_val = {result_q[0], result_q[WIDTH-1:1]};
        step_c   = result_q[0];
      end
    endcase
  end

  // Next-state logic: FSM transitions plus datapath updates.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_d      = c_q;
    op_d     = op_q;
    rem_d    = rem_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StBusy;
      end
      StBusy: begin
        if (last_step) state_d = StDone;
      end
      StDone: begin
        state_d = start ? StBusy : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      result_d = data;
      c_d      = 1'b0;
      op_d     = operation;
      rem_d    = shift_count;
    end else if ((state_q == StBusy) && (rem_q != '0)) begin
      result_d = step_val;
      c_d      = step_c;
      rem_d    = rem_q - CNT_W'(1);
    end
  end

  // Outputs are decoded straight from registers.
  always_comb begin
    result = result_q;
    c      = c_q;
    busy   = (state_q == StBusy);
    done   = (state_q == StDone);
  end

endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: directed self-checking bench for serial_shifter (WIDTH=8, CNT_W=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.

module tb_serial_shifter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] shift_count;
  logic [7:0] data;
  logic [1:0] operation;
  logic [7:0] result;
  logic       c;
  logic       busy;
  logic       done;

  int compared;
  int mismatched;

  serial_shifter #(
    .WIDTH(8),
    .CNT_W(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shift_count(shift_count),
    .data       (data),
    .operation  (operation),
    .result     (result),
    .c          (c),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch an operation from the current cycle, scramble the inputs after acceptance,
  // wait (bounded) for done and check latency, busy length, result and carry.
  task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] n,
                        input logic [1:0] op, input logic [7:0] er, input logic ec,
                        input int elat, input bit hold_check);
    int lat;
    int busyc;
    data        = d;
    shift_count = n;
    operation   = op;
    start       = 1'b1;
    step();
    start       = 1'b0;
    data        = ~d;
    shift_count = ~n;
    operation   = ~op;
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    lat   = 0;
    busyc = 0;
    while ((done !== 1'b1) && (lat < 40)) begin
      busyc += int'(busy);
      step();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy_cycles"}, 32'(busyc), 32'(elat));
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".c"}, 32'(c), 32'(ec));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    if (hold_check) begin
      step();
      check({tag, ".done_fall"}, 32'(done), 32'd0);
      check({tag, ".idle_busy"}, 32'(busy), 32'd0);
      check({tag, ".hold_result"}, 32'(result), 32'(er));
      check({tag, ".hold_c"}, 32'(c), 32'(ec));
    end
  endtask

  initial begin
    int lat;
    int pulses;
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    start       = 1'b1;
    data        = 8'hFF;
    shift_count = 3'd3;
    operation   = 2'b00;
    step();
    step();
    start = 1'b0;
    check("reset.result", 32'(result), 32'h00);
    check("reset.c", 32'(c), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);

    // First start on the very first edge with rst_n high.
    rst_n = 1'b1;
    run_op("sll_05_2", 8'h05, 3'd2, 2'b00, 8'h14, 1'b0, 2, 1'b1);
    run_op("rol_4c_2", 8'h4C, 3'd2, 2'b10, 8'h31, 1'b1, 2, 1'b1);
    run_op("ror_86_7", 8'h86, 3'd7, 2'b11, 8'h0D, 1'b0, 7, 1'b1);
`ifdef SHIFT_ARITH_EN
    run_op("sra_86_2", 8'h86, 3'd2, 2'b01, 8'hE1, 1'b1, 2, 1'b1);
`else
    run_op("srl_86_2", 8'h86, 3'd2, 2'b01, 8'h21, 1'b1, 2, 1'b1);
`endif

    // Zero count, then a back-to-back start issued in the DONE cycle.
    run_op("zero_a5", 8'hA5, 3'd0, 2'b11, 8'hA5, 1'b0, 1, 1'b0);
    check("b2b.done_high", 32'(done), 32'd1);
    run_op("b2b_sll", 8'h05, 3'd2, 2'b00, 8'h14, 1'b0, 2, 1'b1);

    // Start pulsed in BUSY cycle 2 with new inputs must be ignored.
    data        = 8'h0B;
    shift_count = 3'd5;
    operation   = 2'b00;
    start       = 1'b1;
    step();
    start = 1'b0;
    data  = 8'h00;
    step();
    start       = 1'b1;
    data        = 8'hFF;
    shift_count = 3'd1;
    operation   = 2'b11;
    step();
    start = 1'b0;
    lat   = 2;
    while ((done !== 1'b1) && (lat < 40)) begin
      step();
      lat++;
    end
    check("ignore.latency", 32'(lat), 32'd5);
    check("ignore.result", 32'(result), 32'h60);
    check("ignore.c", 32'(c), 32'd1);

    // Reset for one edge in BUSY cycle 3 aborts with no later done pulse.
    step();
    data        = 8'h81;
    shift_count = 3'd7;
    operation   = 2'b11;
    start       = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("abort.pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort.result", 32'(result), 32'h00);
    check("abort.c", 32'(c), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(done);
    end
    check("abort.no_done", 32'(pulses), 32'd0);

    // Normal operation resumes after the abort.
    run_op("post_rol_81_3", 8'h81, 3'd3, 2'b10, 8'h0C, 1'b0, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 3, giving the shift_count width; 2**CNT_W-1 < WIDTH SHALL hold.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request strobe; sampled only when accepted per REQ-012.
REQ-006 SHALL have port shift_count, input, CNT_W, number of bit positions to move.
REQ-007 SHALL have port data, input, WIDTH, operand.
REQ-008 SHALL have port operation, input, 2, with 00 SLL, 01 SRL (SRA per REQ-027), 10 ROL, 11 ROR.
REQ-009 SHALL have port result, output, WIDTH, registered operand/result.
REQ-010 SHALL have port c, output, 1, registered carry: the last bit shifted out or wrapped.
REQ-011 SHALL have ports busy and done, output, 1 each; busy means an operation is in progress, done is a one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, BUSY and DONE, and accept start only in IDLE or DONE.
REQ-013 On an accepted start at edge k, SHALL load result<=data, c<=0, operation and remaining<=shift_count into internal registers, and enter BUSY.
REQ-014 In BUSY, each edge with remaining>0 SHALL move result one position per the latched operation and decrement remaining.
REQ-015 SLL SHALL shift in 0 at the LSB with c<=old MSB; SRL SHALL shift in 0 at the MSB with c<=old LSB.
REQ-016 ROL SHALL feed old MSB into the LSB with c<=old MSB; ROR SHALL feed old LSB into the MSB with c<=old LSB.
REQ-017 When remaining reaches 0, or is 0 on entry, SHALL go BUSY->DONE on that edge with done<=1, so done is high after edge k+max(shift_count,1).
REQ-018 DONE SHALL last exactly one cycle; with no start it SHALL go DONE->IDLE and done<=0.
REQ-019 A start in DONE SHALL be accepted per REQ-013, giving back-to-back operations with no IDLE cycle.
REQ-020 busy SHALL be 1 exactly while in BUSY.
REQ-021 start asserted in BUSY SHALL be ignored, with no effect on the in-flight operation or its inputs.
REQ-022 result and c SHALL hold their final values from done until the next accepted start.
REQ-023 data, shift_count and operation changing after acceptance SHALL NOT affect the operation.

Reset
REQ-024 When rst_n=0 at a rising edge, SHALL force IDLE, result=0, c=0, busy=0, done=0 and remaining=0, overriding start.
REQ-025 Reset asserted mid-operation in BUSY or DONE SHALL abort it, and no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-027 Macro SHIFT_ARITH_EN defined: operation 01 SHALL be arithmetic right shift, replicating the old MSB into the MSB, with c<=old LSB.
REQ-028 Macro SHIFT_ARITH_EN undefined: operation 01 SHALL be logical right shift per REQ-015; all other behaviour is identical in both builds.

Verification
REQ-029 Bench: data=0x05, count=2, op=00, start at edge k -> busy for 2 cycles, done after edge k+2, result=0x14, c=0.
REQ-030 Bench: data=0x4C, count=2, op=10 -> result=0x31, c=1, done after 2 edges; data=0x86, count=7, op=11 -> result=0x0D, c=0, done after 7 edges.
REQ-031 Bench: data=0x86, count=2, op=01 -> result=0x21, c=1 without SHIFT_ARITH_EN; result=0xE1, c=1 with it.
REQ-032 Bench: data=0xA5, count=0, any op -> done after 1 edge, result=0xA5, c=0; a second start in the DONE cycle is accepted and busy rises the next cycle.
REQ-033 Bench: start with count=5, op=00; pulse start with new data at BUSY cycle 2 -> ignored, original result delivered at edge k+5.
REQ-034 Bench: start with count=7; rst_n=0 for one edge at BUSY cycle 3 -> result=0, c=0, busy=0; no done pulse within 10 cycles after.
